imem_fetch_buffer: RTL and testbench

- Parametrised on-chip instruction memory for the single-cycle/pipelined RISC-V core.
- Successor to the fixed 14-bit BRAM instruction store, adding:
  - configurable width and depth;
  - a program-load write port;
  - valid/ready fetch request and response channels;
  - a response FIFO that absorbs core stalls;
  - flush on branch redirect;
  - misaligned-address error tagging.
- Sits between the PC/fetch logic and the decode stage.

---
 rtl/rv_imem_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 86 ++++++++
 rtl/imem_fetch_buffer.sv | 168 ++++++++++++++++
 tb/tb_imem_fetch_buffer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_imem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_imem_pkg
// Description : Shared constants and types for the instruction memory /
//               fetch buffer: default geometry, the NOP word returned on
//               faulting fetches, and the response tag of the default build.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package rv_imem_pkg;

  localparam int C_DATA_W = 32;
  localparam int C_ADDR_W = 14;
  localparam int C_DEPTH  = 4096;

  // addi x0, x0, 0 -- harmless filler for faulting fetches
  localparam logic [31:0] C_NOP_WORD = 32'h0000_0013;

  // Response tag in the default configuration: originating byte address
  // plus the misaligned / out-of-range flag.
  typedef struct packed {
    logic [C_ADDR_W-1:0] addr;
    logic                err;
  } rsp_tag_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Circular-buffer FIFO with first-word fall-through head and an
//               entry count. When empty the head output keeps the value that
//               was last popped, so downstream sees stable data.
// Ports       : clk, rst_n (async, active low), flush (synchronous clear),
//               push/push_data, pop, head_data/head_valid, count
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_last;
  logic             w_do_pop;
  logic             w_do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_do_pop  = pop && (r_count != '0);
  // A push into a full FIFO is only taken when a pop frees the slot in
  // the same cycle; otherwise it is dropped rather than corrupting data.
  assign w_do_push = push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_do_pop) begin
        r_last <= r_mem[r_rd_ptr];
      end
      if (flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_do_push) begin
          r_wr_ptr <= ptr_inc(r_wr_ptr);
        end
        if (w_do_pop) begin
          r_rd_ptr <= ptr_inc(r_rd_ptr);
        end
        case ({w_do_push, w_do_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign head_valid = (r_count != '0);
  assign head_data  = head_valid ? r_mem[r_rd_ptr] : r_last;
  assign count      = r_count;

endmodule
`default_nettype wire

// File: rtl/imem_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_buffer
// Description : Instruction memory with a program-load port and a
//               valid/ready fetch interface. A fetch accepted in cycle t is
//               read from the synchronous RAM at the end of t, written into
//               the response FIFO at the end of t+1 and visible in t+2.
//               Misaligned or out-of-range fetches skip the RAM and return
//               NOP_WORD with rsp_err set, in order with the others.
// Ports       : clk, reset (async, active low)
//               req_valid/req_ready/req_addr      fetch request
//               rsp_valid/rsp_ready/rsp_data/rsp_addr/rsp_err  response
//               ld_en/ld_addr/ld_data             program load (wins over fetch)
//               flush                             drop in-flight + buffered
//               occupancy                         response FIFO fill level
// Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_buffer
  import rv_imem_pkg::*;
#(
  parameter int                DATA_W     = C_DATA_W,
  parameter int                ADDR_W     = C_ADDR_W,
  parameter int                DEPTH      = C_DEPTH,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] NOP_WORD   = DATA_W'(C_NOP_WORD),
  parameter string             INIT_FILE  = "",
  localparam int               OCC_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              flush,
  output logic [OCC_W-1:0]  occupancy
);

  localparam int WORD_IDX_W = ADDR_W - 2;
  localparam int RAM_IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              err;
  } entry_t;

  logic [DATA_W-1:0]    r_mem [DEPTH];
  logic [DATA_W-1:0]    r_ram_q;
  logic                 r_s1_valid;
  logic [ADDR_W-1:0]    r_s1_addr;
  logic                 r_s1_err;

  logic                 w_req_fire;
  logic                 w_req_err;
  logic                 w_req_in_range;
  logic                 w_ld_in_range;
  logic                 w_credit_ok;
  logic                 w_push;
  logic [RAM_IDX_W-1:0] w_req_idx;
  logic [RAM_IDX_W-1:0] w_ld_idx;
  logic [OCC_W-1:0]     w_occupancy;
  logic                 w_fifo_valid;
  entry_t               w_push_entry;
  entry_t               w_head_entry;
  logic                 w_unused_ld_lsbs;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  assign w_req_idx = req_addr[RAM_IDX_W+1:2];
  assign w_ld_idx  = ld_addr[RAM_IDX_W+1:2];
  // Load addresses are word-granular; the byte offset is deliberately ignored.
  assign w_unused_ld_lsbs = ^ld_addr[1:0];

  generate
    if (DEPTH >= (1 << WORD_IDX_W)) begin : g_range_full
      // Every encodable word index maps onto the array.
      assign w_req_in_range = 1'b1;
      assign w_ld_in_range  = 1'b1;
    end else begin : g_range_part
      assign w_req_in_range = (req_addr[ADDR_W-1:2] < WORD_IDX_W'(DEPTH));
      assign w_ld_in_range  = (ld_addr[ADDR_W-1:2] < WORD_IDX_W'(DEPTH));
    end
  endgenerate

  assign w_req_err = (req_addr[1:0] != 2'b00) || !w_req_in_range;

  // --------------------------------------------------------------------------
  // Request acceptance: reserve a FIFO slot for everything buffered plus the
  // one request that may be in stage 1. A pop in this cycle is not credited,
  // which keeps the check independent of rsp_ready.
  // --------------------------------------------------------------------------
  assign w_credit_ok = (32'(w_occupancy) + 32'(r_s1_valid)) < 32'(FIFO_DEPTH);
  assign req_ready   = reset && !flush && !ld_en && w_credit_ok;
  assign w_req_fire  = req_valid && req_ready;

  // --------------------------------------------------------------------------
  // Single-port RAM: the load port owns the array whenever ld_en is high,
  // and req_ready is low in that cycle, so read and write never collide.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ld_en) begin
      if (w_ld_in_range) begin
        r_mem[w_ld_idx] <= ld_data;
      end
    end else if (w_req_fire && !w_req_err) begin
      r_ram_q <= r_mem[w_req_idx];
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: tag travelling alongside the RAM output. Flush blocks
  // acceptance, so the valid flag clears on a flush edge by construction.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_err   <= 1'b0;
    end else begin
      r_s1_valid <= w_req_fire;
      if (w_req_fire) begin
        r_s1_addr <= req_addr;
        r_s1_err  <= w_req_err;
      end
    end
  end

  // The stage-1 result is dropped on flush instead of entering the FIFO.
  assign w_push       = r_s1_valid && !flush;
  assign w_push_entry = '{data: (r_s1_err ? NOP_WORD : r_ram_q),
                          addr: r_s1_addr,
                          err:  r_s1_err};

  // --------------------------------------------------------------------------
  // Response FIFO
  // --------------------------------------------------------------------------
  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .flush      (flush),
    .push       (w_push),
    .push_data  (w_push_entry),
    .pop        (rsp_ready),
    .head_data  (w_head_entry),
    .head_valid (w_fifo_valid),
    .count      (w_occupancy)
  );

  assign rsp_valid = w_fifo_valid;
  assign rsp_data  = w_head_entry.data;
  assign rsp_addr  = w_head_entry.addr;
  assign rsp_err   = w_head_entry.err;
  assign occupancy = w_occupancy;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_fetch_buffer
// Description : Directed self-checking bench for imem_fetch_buffer in its
//               default configuration (32-bit words, 14-bit addresses,
//               4096 words, 4-entry response FIFO).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_buffer;
  import rv_imem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [13:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [13:0] rsp_addr;
  logic        rsp_err;
  logic        ld_en;
  logic [13:0] ld_addr;
  logic [31:0] ld_data;
  logic        flush;
  logic [2:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  // Words preloaded for the backpressure, flush and reset phases.
  logic [13:0] ld_tab_a [5] = '{14'h040, 14'h044, 14'h048, 14'h04C, 14'h020};
  logic [31:0] ld_tab_d [5] = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002,
                                32'hA000_0003, 32'h00A0_0113};
  // Expected req_ready over six back-to-back requests with rsp_ready low.
  logic [5:0]  exp_rdy = 6'b001111;

  always #5 clk = ~clk;

  imem_fetch_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .flush     (flush),
    .occupancy (occupancy)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string name, input logic [31:0] d, input rsp_tag_t t);
    chk({name, "_valid"}, 64'(rsp_valid), 64'(1));
    chk({name, "_data"},  64'(rsp_data),  64'(d));
    chk({name, "_addr"},  64'(rsp_addr),  64'(t.addr));
    chk({name, "_err"},   64'(rsp_err),   64'(t.err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; flush = 1'b0;

    // ---------------- reset held for three cycles ----------------
    #1 reset = 1'b0;
    repeat (3) cyc();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_data",  64'(rsp_data),  64'(0));
    chk("rst_rsp_addr",  64'(rsp_addr),  64'(0));
    chk("rst_rsp_err",   64'(rsp_err),   64'(0));
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    reset = 1'b1;
    #1;
    chk("rel_req_ready", 64'(req_ready), 64'(1));
    chk("rel_rsp_valid", 64'(rsp_valid), 64'(0));

    // ---------------- load then fetch ----------------
    ld_en = 1'b1; ld_addr = 14'h010; ld_data = 32'hDEAD_BEEF;
    #1;
    chk("ld_blocks_req", 64'(req_ready), 64'(0));
    cyc(); ld_addr = 14'h014; ld_data = 32'h0050_0093;
    cyc(); ld_en = 1'b0; rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 14'h010;
    #1;
    chk("fetch0_ready", 64'(req_ready), 64'(1));
    cyc(); req_addr = 14'h014;
    #1;
    chk("fetch1_ready", 64'(req_ready), 64'(1));
    chk("fetch_not_early", 64'(rsp_valid), 64'(0));
    cyc(); req_valid = 1'b0;
    #1;
    chk_rsp("fetch0", 32'hDEAD_BEEF, '{addr: 14'h010, err: 1'b0});
    cyc();
    chk_rsp("fetch1", 32'h0050_0093, '{addr: 14'h014, err: 1'b0});
    cyc();
    chk("drained_valid", 64'(rsp_valid), 64'(0));
    chk("drained_hold",  64'(rsp_data),  64'(32'h0050_0093));

    // ---------------- misaligned request ----------------
    req_valid = 1'b1; req_addr = 14'h012;
    cyc(); req_valid = 1'b0;
    cyc();
    chk_rsp("misaligned", 32'h0000_0013, '{addr: 14'h012, err: 1'b1});

    // ---------------- preload for the remaining phases ----------------
    cyc(); rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ld_en = 1'b1; ld_addr = ld_tab_a[i]; ld_data = ld_tab_d[i];
      cyc();
    end
    ld_en = 1'b0;

    // ---------------- backpressure ----------------
    begin
      int k;
      k = 0;
      for (int i = 0; i < 6; i++) begin
        req_valid = 1'b1; req_addr = 14'h040 + 14'(4 * k);
        #1;
        chk("bp_req_ready", 64'(req_ready), 64'(exp_rdy[i]));
        if (exp_rdy[i]) k++;
        cyc();
      end
    end
    req_valid = 1'b0;
    #1;
    chk("bp_occupancy", 64'(occupancy), 64'(4));
    chk("bp_full_ready", 64'(req_ready), 64'(0));
    chk_rsp("bp_stall0", 32'hA000_0000, '{addr: 14'h040, err: 1'b0});
    cyc();
    chk_rsp("bp_stall1", 32'hA000_0000, '{addr: 14'h040, err: 1'b0});
    cyc(); rsp_ready = 1'b1;
    #1;
    chk_rsp("bp_drain0", 32'hA000_0000, '{addr: 14'h040, err: 1'b0});
    for (int j = 1; j < 4; j++) begin
      cyc();
      chk_rsp("bp_drain", 32'hA000_0000 + 32'(j), '{addr: 14'h040 + 14'(4 * j), err: 1'b0});
    end
    cyc();
    chk("bp_empty_valid", 64'(rsp_valid), 64'(0));
    chk("bp_empty_occ",   64'(occupancy), 64'(0));

    // ---------------- flush ----------------
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 14'h040;
    cyc(); req_addr = 14'h044;
    cyc(); req_addr = 14'h048; flush = 1'b1;
    #1;
    chk("flush_blocks_req", 64'(req_ready), 64'(0));
    chk("flush_pre_occ",    64'(occupancy), 64'(1));
    cyc(); req_valid = 1'b0; flush = 1'b0;
    #1;
    chk("flush_valid0", 64'(rsp_valid), 64'(0));
    chk("flush_occ0",   64'(occupancy), 64'(0));
    cyc();
    chk("flush_valid1", 64'(rsp_valid), 64'(0));
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 14'h020;
    #1;
    chk("post_flush_ready", 64'(req_ready), 64'(1));
    cyc(); req_valid = 1'b0;
    #1;
    chk("post_flush_early", 64'(rsp_valid), 64'(0));
    cyc();
    chk_rsp("post_flush", 32'h00A0_0113, '{addr: 14'h020, err: 1'b0});

    // ---------------- flush together with a load ----------------
    cyc(); flush = 1'b1; ld_en = 1'b1; ld_addr = 14'h024; ld_data = 32'h1234_5678;
    cyc(); flush = 1'b0; ld_en = 1'b0; req_valid = 1'b1; req_addr = 14'h024;
    cyc(); req_valid = 1'b0;
    cyc();
    chk_rsp("flush_load", 32'h1234_5678, '{addr: 14'h024, err: 1'b0});

    // ---------------- reset during operation ----------------
    cyc(); rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 14'h040;
    cyc(); req_addr = 14'h044;
    cyc(); req_addr = 14'h048;
    cyc(); req_valid = 1'b0;
    #1;
    chk("mid_pre_occ",   64'(occupancy), 64'(2));
    chk("mid_pre_valid", 64'(rsp_valid), 64'(1));
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(rsp_valid), 64'(0));
    chk("mid_rst_occ",   64'(occupancy), 64'(0));
    chk("mid_rst_data",  64'(rsp_data),  64'(0));
    cyc();
    cyc(); reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("no_stale_valid", 64'(rsp_valid), 64'(0));
      chk("no_stale_occ",   64'(occupancy), 64'(0));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
